// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decodes fetched instructions on entry and queues the decoded bundles for execute
module decode_queue #(
  parameter int XLEN       = 32,
  parameter int REG_W      = 5,
  parameter int IMM_W      = 17,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [XLEN-1:0]                 in_instr,
  input  logic [XLEN-1:0]                 in_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XLEN-1:0]                 out_pc,
  output logic [4:0]                      opcode,
  output logic [REG_W-1:0]                rd,
  output logic [REG_W-1:0]                rs,
  output logic [REG_W-1:0]                rt,
  output logic [4:0]                      shamt,
  output logic [4:0]                      alu_op,
  output logic [XLEN-1:0]                 immediate,
  output logic [XLEN-1:0]                 target,
  output logic                            r_type,
  output logic                            i_type,
  output logic                            ji_type,
  output logic                            jii_type,
  output logic                            illegal,
  output logic [$clog2(FIFO_DEPTH):0]     count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [4:0]       opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [4:0]       shamt;
    logic [4:0]       alu_op;
    logic [XLEN-1:0]  immediate;
    logic [XLEN-1:0]  target;
    logic             r_type;
    logic             i_type;
    logic             ji_type;
    logic             jii_type;
    logic             illegal;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [4:0]      opc;
  logic            push;
  logic            pop;
  logic            is_r, is_j, is_bne, is_jal, is_jr, is_addi;
  logic            is_blt, is_sw, is_lw, is_setx, is_bex;

  assign in_ready  = (count < CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign opc     = in_instr[31:27];
  assign is_r    = (opc == 5'b00000);
  assign is_j    = (opc == 5'b00001);
  assign is_bne  = (opc == 5'b00010);
  assign is_jal  = (opc == 5'b00011);
  assign is_jr   = (opc == 5'b00100);
  assign is_addi = (opc == 5'b00101);
  assign is_blt  = (opc == 5'b00110);
  assign is_sw   = (opc == 5'b00111);
  assign is_lw   = (opc == 5'b01000);
  assign is_setx = (opc == 5'b10101);
  assign is_bex  = (opc == 5'b10110);

  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.opcode    = opc;
    dec.rd        = in_instr[26 -: REG_W];
    dec.shamt     = in_instr[11:7];
    dec.alu_op    = in_instr[6:2];
    dec.immediate = {{(XLEN-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
    dec.target    = {{(XLEN-27){1'b0}}, in_instr[26:0]};
    // Branches and jr read the register that sits in the rd slot.
    if (is_bne || is_blt || is_jr) dec.rs = in_instr[26 -: REG_W];
    else                           dec.rs = in_instr[21 -: REG_W];
    if (is_bne || is_blt)          dec.rt = in_instr[21 -: REG_W];
    else if (is_sw)                dec.rt = in_instr[26 -: REG_W];
    else if (is_bex)               dec.rt = REG_W'(30);
    else                           dec.rt = in_instr[16 -: REG_W];
    dec.r_type   = is_r;
    dec.i_type   = is_addi | is_sw | is_lw | is_bne | is_blt;
    dec.ji_type  = is_j | is_jal | is_bex | is_setx;
    dec.jii_type = is_jr;
    dec.illegal  = ~(is_r | is_j | is_bne | is_jal | is_jr | is_addi |
                     is_blt | is_sw | is_lw | is_setx | is_bex);
  end

  // Storage is cleared on reset so the head (slot 0) drives zeros afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_pc    = head.pc;
  assign opcode    = head.opcode;
  assign rd        = head.rd;
  assign rs        = head.rs;
  assign rt        = head.rt;
  assign shamt     = head.shamt;
  assign alu_op    = head.alu_op;
  assign immediate = head.immediate;
  assign target    = head.target;
  assign r_type    = head.r_type;
  assign i_type    = head.i_type;
  assign ji_type   = head.ji_type;
  assign jii_type  = head.jii_type;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard bench for decode_queue
module tb_decode_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  op, rd, rs, rt, sh, alu;
    logic [31:0] imm, tgt;
    logic [4:0]  fl;  // {r, i, ji, jii, illegal}
  } exp_t;

  localparam logic [4:0] F_R = 5'b10000, F_I = 5'b01000, F_JI = 5'b00100,
                         F_JII = 5'b00010, F_ILL = 5'b00001;

  logic        clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [31:0] out_pc, immediate, target;
  logic [4:0]  opcode, rd, rs, rt, shamt, alu_op;
  logic        r_type, i_type, ji_type, jii_type, illegal;
  logic [1:0]  count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  decode_queue dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .alu_op(alu_op),
    .immediate(immediate), .target(target),
    .r_type(r_type), .i_type(i_type), .ji_type(ji_type), .jii_type(jii_type),
    .illegal(illegal), .count(count)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(logic [31:0] pc, logic [4:0] op, logic [4:0] rd_v,
                              logic [4:0] rs_v, logic [4:0] rt_v, logic [4:0] sh,
                              logic [4:0] alu, logic [31:0] imm, logic [31:0] tgt,
                              logic [4:0] fl);
    exp_t e;
    e.pc = pc; e.op = op; e.rd = rd_v; e.rs = rs_v; e.rt = rt_v; e.sh = sh;
    e.alu = alu; e.imm = imm; e.tgt = tgt; e.fl = fl;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive one instruction and book its expected bundle once the DUT will take it.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    bit ok = 0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready && !flush && !reset) begin
        exp_q.push_back(e);
        @(posedge clock); #1;
        in_valid = 1'b0;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles required acceptance of pc %h", pc);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_empty();
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (count == 2'd0 && exp_q.size() == 0) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_timeout: got count=%0d pending=%0d required 0/0", count, exp_q.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_count"},     32'(count),     32'd0);
    chk({tag, "_out_pc"},    out_pc,         32'd0);
    chk({tag, "_fields"},    32'({opcode, rd, rs, rt, shamt, alu_op}), 32'd0);
    chk({tag, "_immediate"}, immediate,      32'd0);
    chk({tag, "_target"},    target,         32'd0);
    chk({tag, "_flags"},     32'({r_type, i_type, ji_type, jii_type, illegal}), 32'd0);
  endtask

  always @(negedge clock) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL spurious_output: got out_pc=%h required no output", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_pc",    out_pc,          mon_e.pc);
        chk("opcode",    32'(opcode),     32'(mon_e.op));
        chk("rd",        32'(rd),         32'(mon_e.rd));
        chk("rs",        32'(rs),         32'(mon_e.rs));
        chk("rt",        32'(rt),         32'(mon_e.rt));
        chk("shamt",     32'(shamt),      32'(mon_e.sh));
        chk("alu_op",    32'(alu_op),     32'(mon_e.alu));
        chk("immediate", immediate,       mon_e.imm);
        chk("target",    target,          mon_e.tgt);
        chk("flags",     32'({r_type, i_type, ji_type, jii_type, illegal}), 32'(mon_e.fl));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_reset_state("reset");

    // Decode vectors at full throughput
    out_ready = 1'b1;
    send(32'h28C20005, 32'h10, mk(32'h10, 5'd5, 5'd3, 5'd1, 5'd0, 5'd0, 5'd1, 32'h5, 32'h0C20005, F_I));
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("latency_count",     32'(count),     32'd1);
    send(32'h2841FFFF, 32'h14, mk(32'h14, 5'd5, 5'd1, 5'd0, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 32'h041FFFF, F_I));
    send(32'h38860004, 32'h18, mk(32'h18, 5'd7, 5'd2, 5'd3, 5'd2, 5'd0, 5'd1, 32'h4, 32'h0860004, F_I));
    send(32'hB0000123, 32'h1C, mk(32'h1C, 5'd22, 5'd0, 5'd0, 5'd30, 5'd2, 5'd8, 32'h123, 32'h123, F_JI));
    send(32'h20800000, 32'h20, mk(32'h20, 5'd4, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0800000, F_JII));
    chk("throughput_count", 32'(count), 32'd1);
    wait_empty();

    // Back-pressure, then full with valid/ready both high
    out_ready = 1'b0;
    send(32'h08000010, 32'h100, mk(32'h100, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h10, 32'h10, F_JI));
    send(32'h00443088, 32'h104, mk(32'h104, 5'd0, 5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 32'h3088, 32'h0443088, F_R));
    chk("full_count",    32'(count),    32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(32'h10C40000, 32'h108, mk(32'h108, 5'd2, 5'd3, 5'd3, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0C40000, F_I));
    join_none
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("hold_out_pc",   out_pc,         32'h100);
      chk("hold_opcode",   32'(opcode),    32'd1);
      chk("hold_in_ready", 32'(in_ready),  32'd0);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(posedge clock); #1;
    chk("pop_no_push_count", 32'(count),    32'd1);
    chk("pop_in_ready",      32'(in_ready), 32'd1);
    @(posedge clock); #1;
    chk("push_pop_count",    32'(count),    32'd1);
    wait_empty();

    // Flush with a pending input and pop request
    out_ready = 1'b0;
    send(32'h28C20005, 32'h200, mk(32'h200, 5'd5, 5'd3, 5'd1, 5'd0, 5'd0, 5'd1, 32'h5, 32'h0C20005, F_I));
    send(32'h38860004, 32'h204, mk(32'h204, 5'd7, 5'd2, 5'd3, 5'd2, 5'd0, 5'd1, 32'h4, 32'h0860004, F_I));
    chk("preflush_count", 32'(count), 32'd2);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h20800000; in_pc = 32'h208;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clock); #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush_count",     32'(count),     32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    @(posedge clock); #1;
    chk("flush_dropped_count", 32'(count), 32'd0);

    // Illegal opcode still flows through
    send(32'hF8000000, 32'h300, mk(32'h300, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, F_ILL));
    wait_empty();

    // Reset mid-stream
    out_ready = 1'b0;
    send(32'hB0000123, 32'h400, mk(32'h400, 5'd22, 5'd0, 5'd0, 5'd30, 5'd2, 5'd8, 32'h123, 32'h123, F_JI));
    send(32'h2841FFFF, 32'h404, mk(32'h404, 5'd5, 5'd1, 5'd0, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 32'h041FFFF, F_I));
    chk("prereset_count", 32'(count), 32'd2);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1 reset = 1'b0;
    chk_reset_state("midreset");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
